calc_scheduler: RTL



---
 rtl/calc_scheduler_pkg.sv | 18 +
 rtl/calc_scheduler_calculadora.sv | 46 ++++
 rtl/calc_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/calc_scheduler_pkg.sv
// Shared definitions for the calculator scheduler: widths, opcodes, FSM encoding.
package calc_scheduler_pkg;

    localparam int W_OPD = 7;
    localparam int W_RES = 2 * W_OPD;

    localparam logic [1:0] OP_ESP  = 2'd0;
    localparam logic [1:0] OP_SUM  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/calc_scheduler_calculadora.sv
// Combinational arithmetic datapath: sum, absolute difference with sign, multiply, idle.
module calculadora
    import calc_scheduler_pkg::*;
#(
    parameter int W_OPD = calc_scheduler_pkg::W_OPD,
    parameter int W_RES = calc_scheduler_pkg::W_RES
) (
    input  logic [W_OPD-1:0] x,
    input  logic [W_OPD-1:0] y,
    input  logic [1:0]       op,
    output logic [W_RES-1:0] result,
    output logic             signal
);

    // |a - b| computed in signed arithmetic one bit wider than the operands
    function automatic logic [W_RES-1:0] abs_diff(input logic [W_OPD-1:0] a,
                                                  input logic [W_OPD-1:0] b);
        logic signed [W_OPD:0] d;
        logic        [W_OPD:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = (d < 0) ? $unsigned(-d) : $unsigned(d);
        return {{(W_RES-W_OPD-1){1'b0}}, m};
    endfunction

    logic [W_RES-1:0] xe;
    logic [W_RES-1:0] ye;

    assign xe = {{(W_RES-W_OPD){1'b0}}, x};
    assign ye = {{(W_RES-W_OPD){1'b0}}, y};

    // Opcode decode; operand ranges guarantee no result overflow
    always_comb begin
        result = '0;
        signal = 1'b0;
        case (op)
            OP_SUM:  result = xe + ye;
            OP_SUB: begin
                result = abs_diff(x, y);
                signal = (y > x);
            end
            OP_MULT: result = xe * ye;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/calc_scheduler.sv
// Round-robin scheduler sharing one calculadora between two requesters.
module calc_scheduler
    import calc_scheduler_pkg::*;
#(
    parameter int W_OPD = calc_scheduler_pkg::W_OPD,
    parameter int W_RES = calc_scheduler_pkg::W_RES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [W_OPD-1:0] x0,
    input  logic [W_OPD-1:0] y0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [W_OPD-1:0] x1,
    input  logic [W_OPD-1:0] y1,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [W_RES-1:0] result,
    output logic             signal,
    output logic             result_id,
    output logic             busy
);

    state_t           state;
    logic [W_OPD-1:0] x_q;
    logic [W_OPD-1:0] y_q;
    logic [1:0]       op_q;
    logic             owner_q;
    logic             ptr_q;     // 0 favours requester 0, 1 favours requester 1

    logic             any_req;
    logic             win;
    logic [1:0]       dp_op;
    logic [W_RES-1:0] dp_result;
    logic             dp_signal;

    // Arbitration: a lone requester wins, a tie goes to the favoured one
    always_comb begin
        any_req = req0 | req1;
        win     = 1'b0;
        if (req0 && req1)
            win = ptr_q;
        else
            win = req1;
    end

    // The datapath only sees a real opcode while executing; otherwise it idles
    assign dp_op = (state == EXEC) ? op_q : OP_ESP;

    calculadora #(
        .W_OPD (W_OPD),
        .W_RES (W_RES)
    ) u_calc (
        .x      (x_q),
        .y      (y_q),
        .op     (dp_op),
        .result (dp_result),
        .signal (dp_signal)
    );

    // Control FSM with registered handshake, result and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= OP_ESP;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= '0;
            signal    <= 1'b0;
            result_id <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        x_q     <= win ? x1  : x0;
                        y_q     <= win ? y1  : y0;
                        op_q    <= win ? op1 : op0;
                        owner_q <= win;
                        ptr_q   <= ~win;
                        gnt0    <= ~win;
                        gnt1    <= win;
                        state   <= EXEC;
                        busy    <= 1'b1;
                    end
                end
                EXEC: begin
                    result    <= dp_result;
                    signal    <= dp_signal;
                    result_id <= owner_q;
                    done0     <= ~owner_q;
                    done1     <= owner_q;
                    state     <= DONE;
                    busy      <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
